ram_sync: RTL and testbench

RAM_SYNC -- requirements
Module: ram_sync

---
 rtl/ram_sync.sv | 138 +++++++++++++
 tb/tb_ram_sync.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/ram_sync.sv
// ram_sync: single-port synchronous RAM with a post-reset zero-fill sequence,
// one-cycle registered read (read-first on collisions) and an out-of-range
// error pulse. Address decode uses the full address width with no aliasing.
module ram_sync #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 8,
    parameter int DEPTH          = 11,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  writeOn,
    input  logic                  readOn,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  busy,
    output logic                  err
);

    // Index width large enough to address every stored word (at least 1 bit).
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // DEPTH widened by one bit so the range compare never truncates.
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);

    // Final word index of the clear sweep.
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    // Controller state after reset depends on whether a zero-fill is wanted.
    localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];

    state_t                state_r;
    logic [IDX_W-1:0]      cnt_r;
    logic [DATA_WIDTH-1:0] data_out_r;
    logic                  valid_r;
    logic                  busy_r;
    logic                  err_r;

    logic                  in_range_s;
    logic [IDX_W-1:0]      idx_s;
    logic                  rd_ok_s;
    logic                  req_bad_s;
    logic                  mem_we_s;
    logic [IDX_W-1:0]      mem_waddr_s;
    logic [DATA_WIDTH-1:0] mem_wdata_s;

    // Full-width range check; only in-range addresses are used to index memory.
    always_comb begin
        in_range_s = ({1'b0, address} < DEPTH_C);
        idx_s      = address[IDX_W-1:0];
        rd_ok_s    = (state_r == ST_READY) && readOn && in_range_s;
        req_bad_s  = (state_r == ST_READY) && (readOn || writeOn) && !in_range_s;
    end

    // Memory write port: zero-fill during clear, user writes when ready; nothing while in reset.
    always_comb begin
        mem_we_s    = 1'b0;
        mem_waddr_s = cnt_r;
        mem_wdata_s = {DATA_WIDTH{1'b0}};
        if (!rst_n) begin
            mem_we_s = 1'b0;
        end else if (state_r == ST_CLEAR) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = cnt_r;
            mem_wdata_s = {DATA_WIDTH{1'b0}};
        end else if (writeOn && in_range_s) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = idx_s;
            mem_wdata_s = data_in;
        end else begin
            mem_we_s = 1'b0;
        end
    end

    // Storage array; deliberately not reset so contents survive reset when no fill is requested.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[mem_waddr_s] <= mem_wdata_s;
        end
    end

    // Controller FSM with registered outputs; the read samples the pre-write word (read-first).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= RESET_STATE;
            busy_r     <= (RESET_STATE == ST_CLEAR);
            cnt_r      <= {IDX_W{1'b0}};
            data_out_r <= {DATA_WIDTH{1'b0}};
            valid_r    <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_CLEAR: begin
                    valid_r <= 1'b0;
                    err_r   <= 1'b0;
                    if (cnt_r == LAST_IDX) begin
                        state_r <= ST_READY;
                        busy_r  <= 1'b0;
                        cnt_r   <= {IDX_W{1'b0}};
                    end else begin
                        busy_r  <= 1'b1;
                        cnt_r   <= cnt_r + IDX_W'(1'b1);
                    end
                end
                ST_READY: begin
                    busy_r  <= 1'b0;
                    valid_r <= rd_ok_s;
                    err_r   <= req_bad_s;
                    if (rd_ok_s) begin
                        data_out_r <= mem_r[idx_s];
                    end
                end
                default: begin
                    state_r <= ST_READY;
                    busy_r  <= 1'b0;
                    cnt_r   <= {IDX_W{1'b0}};
                    valid_r <= 1'b0;
                    err_r   <= 1'b0;
                end
            endcase
        end
    end

    assign data_out  = data_out_r;
    assign valid_out = valid_r;
    assign busy      = busy_r;
    assign err       = err_r;

endmodule

// File: tb/tb_ram_sync.sv
// Self-checking bench for ram_sync: directed scenarios plus a randomized phase,
// all checked against a word-array reference model kept in the bench.
module tb_ram_sync;

    localparam int DW    = 8;
    localparam int AW    = 8;
    localparam int DEPTH = 11;

    logic          clk;
    logic          rst_n;
    logic [AW-1:0] address;
    logic [DW-1:0] data_in;
    logic          writeOn;
    logic          readOn;
    logic [DW-1:0] data_out;
    logic          valid_out;
    logic          busy;
    logic          err;

    logic          rst0_n;
    logic [AW-1:0] address0;
    logic [DW-1:0] data_in0;
    logic          writeOn0;
    logic          readOn0;
    logic [DW-1:0] data_out0;
    logic          valid_out0;
    logic          busy0;
    logic          err0;

    ram_sync #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .CLEAR_ON_RESET(1)) dut (
        .clk(clk), .rst_n(rst_n), .address(address), .data_in(data_in),
        .writeOn(writeOn), .readOn(readOn), .data_out(data_out),
        .valid_out(valid_out), .busy(busy), .err(err)
    );

    ram_sync #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .CLEAR_ON_RESET(0)) dut0 (
        .clk(clk), .rst_n(rst0_n), .address(address0), .data_in(data_in0),
        .writeOn(writeOn0), .readOn(readOn0), .data_out(data_out0),
        .valid_out(valid_out0), .busy(busy0), .err(err0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int            n_total = 0;
    int            n_pass  = 0;
    logic [DW-1:0] model [0:255];
    logic [DW-1:0] exp_dout;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One bus cycle on the main DUT: drive, let the model predict, then compare.
    task automatic step(input logic rd, input logic wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input string tag);
        logic in_rng;
        logic exp_valid;
        logic exp_err;
        readOn  = rd;
        writeOn = wr;
        address = a;
        data_in = d;
        in_rng    = (int'(a) < DEPTH);
        exp_valid = rd && in_rng;
        exp_err   = (rd || wr) && !in_rng;
        if (rd && in_rng) exp_dout = model[a];
        if (wr && in_rng) model[a] = d;
        @(negedge clk);
        check({tag, " data_out"}, 32'(data_out), 32'(exp_dout));
        check({tag, " valid_out"}, 32'(valid_out), 32'(exp_valid));
        check({tag, " err"}, 32'(err), 32'(exp_err));
        check({tag, " busy"}, 32'(busy), 32'd0);
    endtask

    // Count consecutive busy cycles starting at the current (release) cycle.
    task automatic count_busy(output int cnt, output logic saw_pulse);
        cnt       = 0;
        saw_pulse = 1'b0;
        while (busy && cnt < 100) begin
            cnt++;
            @(negedge clk);
            if (valid_out || err) saw_pulse = 1'b1;
        end
    endtask

    initial begin
        int   bcnt;
        logic pulse;
        logic [AW-1:0] ra;

        rst_n = 1'b0; address = 8'd0; data_in = 8'd0; writeOn = 1'b0; readOn = 1'b0;
        rst0_n = 1'b0; address0 = 8'd0; data_in0 = 8'd0; writeOn0 = 1'b0; readOn0 = 1'b0;
        exp_dout = 8'd0;
        @(negedge clk);
        @(negedge clk);

        // Reset state
        check("rst data_out", 32'(data_out), 32'd0);
        check("rst valid_out", 32'(valid_out), 32'd0);
        check("rst err", 32'(err), 32'd0);
        check("rst busy", 32'(busy), 32'd1);
        check("rst0 busy", 32'(busy0), 32'd0);
        check("rst0 data_out", 32'(data_out0), 32'd0);

        // Release; hammer requests during the clear, they must be ignored
        rst_n = 1'b1; rst0_n = 1'b1;
        readOn = 1'b1; writeOn = 1'b1; address = 8'd0; data_in = 8'hFF;
        count_busy(bcnt, pulse);
        check("clear busy cycles", 32'(bcnt), 32'(DEPTH));
        check("clear no pulses", 32'(pulse), 32'd0);
        check("busy0 idle", 32'(busy0), 32'd0);
        for (int i = 0; i < 256; i++) model[i] = 8'd0;
        exp_dout = 8'd0;
        readOn = 1'b0; writeOn = 1'b0;
        // That edge (first READY edge) had rd+wr at addr 0 applied; account for it
        // by re-driving nothing: inputs were changed before the edge, so only idle here.
        step(1'b0, 1'b0, 8'd0, 8'd0, "idle after clear");

        // Back-to-back sweep of cleared words
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 8'(i), 8'd0, "sweep clear");
        step(1'b0, 1'b0, 8'd0, 8'd0, "hold after sweep");

        // Write then read
        step(1'b0, 1'b1, 8'd3, 8'hA5, "wr3");
        step(1'b1, 1'b0, 8'd3, 8'h00, "rd3");

        // Read-first collision
        step(1'b0, 1'b1, 8'd5, 8'h11, "wr5");
        step(1'b1, 1'b1, 8'd5, 8'h22, "rdwr5");
        step(1'b1, 1'b0, 8'd5, 8'h00, "rd5 new");

        // Out of range requests
        step(1'b0, 1'b1, 8'd11, 8'h5A, "wr11 err");
        step(1'b0, 1'b0, 8'd0, 8'h00, "err one pulse");
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 8'(i), 8'd0, "sweep after oob");
        step(1'b1, 1'b0, 8'd200, 8'h00, "rd200 err");
        step(1'b1, 1'b1, 8'd255, 8'h77, "rdwr255 err");
        step(1'b0, 1'b0, 8'd0, 8'h00, "err cleared");

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 7) == 0) ra = 8'($urandom_range(16, 255));
            else ra = 8'($urandom_range(0, 15));
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra,
                 8'($urandom_range(0, 255)), "rand");
        end

        // Reset mid-clear restarts the sweep; a write during clear is dropped
        readOn = 1'b0; writeOn = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;                                   // cycle 1
        @(negedge clk);                                 // cycle 2
        @(negedge clk);                                 // cycle 3
        @(negedge clk);                                 // cycle 4
        writeOn = 1'b1; address = 8'd2; data_in = 8'h77;
        @(negedge clk);                                 // cycle 5
        writeOn = 1'b0;
        @(negedge clk);                                 // cycle 6
        rst_n = 1'b0;
        @(negedge clk);
        check("midclear rst busy", 32'(busy), 32'd1);
        check("midclear rst data_out", 32'(data_out), 32'd0);
        rst_n = 1'b1;
        count_busy(bcnt, pulse);
        check("restart busy cycles", 32'(bcnt), 32'(DEPTH));
        check("restart no pulses", 32'(pulse), 32'd0);
        for (int i = 0; i < 256; i++) model[i] = 8'd0;
        exp_dout = 8'd0;
        step(1'b1, 1'b0, 8'd2, 8'h00, "rd2 after restart");
        step(1'b1, 1'b0, 8'd10, 8'h00, "rd10 after restart");

        // No-fill instance: contents survive reset, request on the reset edge is dropped
        writeOn0 = 1'b1; address0 = 8'd7; data_in0 = 8'h3C;
        @(negedge clk);
        check("nf busy", 32'(busy0), 32'd0);
        rst0_n = 1'b0; readOn0 = 1'b1; writeOn0 = 1'b1; data_in0 = 8'h55;
        @(negedge clk);
        check("nf rst data_out", 32'(data_out0), 32'd0);
        check("nf rst valid", 32'(valid_out0), 32'd0);
        check("nf rst err", 32'(err0), 32'd0);
        check("nf rst busy", 32'(busy0), 32'd0);
        rst0_n = 1'b1; writeOn0 = 1'b0; readOn0 = 1'b1;
        @(negedge clk);
        check("nf rd7 data", 32'(data_out0), 32'h3C);
        check("nf rd7 valid", 32'(valid_out0), 32'd1);
        check("nf rd7 busy", 32'(busy0), 32'd0);
        readOn0 = 1'b0;
        @(negedge clk);
        check("nf valid drop", 32'(valid_out0), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
